// File: rtl/lf_pkg.sv
// Shared types and elaboration helpers for the Ladner-Fischer pipelined adder.
package lf_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // Number of registered prefix slices for a given width and levels per slice.
   function automatic int calc_stages(input int width, input int lvl_per_stg);
      return ($clog2(width) + lvl_per_stg - 1) / lvl_per_stg;
   endfunction

   // Most significant bit of the lower group that bit i absorbs at level l.
   function automatic int lf_partner(input int l, input int i);
      return ((i >> (l - 1)) << (l - 1)) - 1;
   endfunction

endpackage

// File: rtl/lf_pg_cell.sv
// Black cell of the prefix network: merges a high group with the adjacent lower group.
module lf_pg_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);
   assign g = gh | (ph & gl);
   assign p = ph & pl;
endmodule

// File: rtl/ladner_fischer_pipe.sv
// Pipelined parallel-prefix adder with a single global advance enable.
// Define LF_APPROX_EN for a lower-part-OR approximation of the low APPROX_BITS bits.
module ladner_fischer_pipe
   import lf_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int LVL_PER_STG = 2,
   parameter int APPROX_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int LOG2W = $clog2(WIDTH);
`ifdef LF_APPROX_EN
   localparam bit APPROX_EN = 1'b1;
`else
   localparam bit APPROX_EN = 1'b0;
`endif
   localparam int LOW = APPROX_EN ? APPROX_BITS : 0;

   logic en;
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   // Approximate low bits are removed from the prefix network; only the top
   // low bit's generate survives, acting as the carry into bit LOW.
   pg_t [WIDTH-1:0]  pg_in;
   logic [WIDTH-1:0] xp_in;
   logic             ci_in;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pg_in[i].g = a[i] & b[i];
         pg_in[i].p = a[i] ^ b[i];
         xp_in[i]   = a[i] ^ b[i];
         if (i < LOW) begin
            pg_in[i].p = 1'b0;
            xp_in[i]   = a[i] | b[i];
            if (i != LOW - 1) pg_in[i].g = 1'b0;
         end
      end
      ci_in = (LOW == 0) ? cin : 1'b0;
   end

   generate
      for (genvar l = 0; l <= LOG2W; l++) begin : lvl
         pg_t [WIDTH-1:0]  pg;
         logic [WIDTH-1:0] xp;
         logic             ci;
         logic             vld;

         if (l == 0) begin : s0
            // ---- slice S0: pre-processed operands ----
            always_ff @(posedge clk) begin
               if (en) begin
                  pg <= pg_in;
                  xp <= xp_in;
                  ci <= ci_in;
               end
            end
            always_ff @(posedge clk or posedge rst) begin
               if (rst)     vld <= 1'b0;
               else if (en) vld <= in_valid;
            end
         end else begin : net
            pg_t [WIDTH-1:0] comb;

            for (genvar i = 0; i < WIDTH; i++) begin : bits
               if (((i >> (l - 1)) % 2) == 1) begin : blk
                  lf_pg_cell u_cell (
                     .gh (lvl[l-1].pg[i].g),
                     .ph (lvl[l-1].pg[i].p),
                     .gl (lvl[l-1].pg[lf_partner(l, i)].g),
                     .pl (lvl[l-1].pg[lf_partner(l, i)].p),
                     .g  (comb[i].g),
                     .p  (comb[i].p)
                  );
               end else begin : pass
                  assign comb[i] = lvl[l-1].pg[i];
               end
            end

            if (((l % LVL_PER_STG) == 0) || (l == LOG2W)) begin : slice
               // ---- prefix slice boundary after level l ----
               always_ff @(posedge clk) begin
                  if (en) begin
                     pg <= comb;
                     xp <= lvl[l-1].xp;
                     ci <= lvl[l-1].ci;
                  end
               end
               always_ff @(posedge clk or posedge rst) begin
                  if (rst)     vld <= 1'b0;
                  else if (en) vld <= lvl[l-1].vld;
               end
            end else begin : thru
               assign pg  = comb;
               assign xp  = lvl[l-1].xp;
               assign ci  = lvl[l-1].ci;
               assign vld = lvl[l-1].vld;
            end
         end
      end
   endgenerate

   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_nxt;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         carry[i] = lvl[LOG2W].pg[i].g | (lvl[LOG2W].pg[i].p & lvl[LOG2W].ci);
      end
      sum_nxt[0] = lvl[LOG2W].xp[0] ^ lvl[LOG2W].ci;
      for (int i = 1; i < WIDTH; i++) begin
         sum_nxt[i] = lvl[LOG2W].xp[i] ^ carry[i-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (i < LOW) sum_nxt[i] = lvl[LOG2W].xp[i];
      end
   end

   // ---- output slice: post-processed sum ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else if (en) begin
         out_valid <= lvl[LOG2W].vld;
         sum       <= sum_nxt;
         cout      <= carry[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_ladner_fischer_pipe.sv
// Directed and randomised checks of ladner_fischer_pipe at WIDTH=16, LVL_PER_STG=2.
module tb_ladner_fischer_pipe;
   localparam int W  = 16;
   localparam int AB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;
   logic [W:0] q[$];

   always #5 clk = ~clk;

   ladner_fischer_pipe #(.WIDTH(W), .LVL_PER_STG(2), .APPROX_BITS(AB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
`ifdef LF_APPROX_EN
      logic [W-AB:0] hi;
      hi = {1'b0, x[W-1:AB]} + {1'b0, y[W-1:AB]} + (W-AB+1)'(x[AB-1] & y[AB-1]);
      return {hi, x[AB-1:0] | y[AB-1:0]};
`else
      return {1'b0, x} + {1'b0, y} + (W+1)'(c);
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
   endtask

   logic [W-1:0] ta[4];
   logic [W-1:0] tb[4];
   logic         tc[4];
   logic [W-1:0] es[4];
   logic         ec[4];

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_sum",       64'(sum),       64'(0));
      check("rst_cout",      64'(cout),      64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      rst = 1'b0;
      tick();

`ifndef LF_APPROX_EN
      // single beat latency and wrap-around carry
      drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      check("lat_in_ready", 64'(in_ready), 64'(1));
      tick();
      drive(1'b0, '0, '0, 1'b0);
      check("lat_e0", 64'(out_valid), 64'(0));
      tick();
      check("lat_e1", 64'(out_valid), 64'(0));
      tick();
      check("lat_e2", 64'(out_valid), 64'(0));
      tick();
      check("lat_e3_valid", 64'(out_valid), 64'(1));
      check("lat_e3_sum",   64'(sum),       64'(16'h0000));
      check("lat_e3_cout",  64'(cout),      64'(1));
      tick();
      check("lat_gone", 64'(out_valid), 64'(0));

      // back-to-back stream
      ta = '{16'd1, 16'd3, 16'h8000, 16'h1234};
      tb = '{16'd2, 16'd4, 16'h8000, 16'h4321};
      tc = '{1'b0, 1'b1, 1'b0, 1'b0};
      es = '{16'd3, 16'd8, 16'h0000, 16'h5555};
      ec = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ta[k], tb[k], tc[k]);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("b2b_valid%0d", k), 64'(out_valid), 64'(1));
         check($sformatf("b2b_sum%0d", k),   64'(sum),       64'(es[k]));
         check($sformatf("b2b_cout%0d", k),  64'(cout),      64'(ec[k]));
         tick();
      end
      check("b2b_gone", 64'(out_valid), 64'(0));

      // backpressure: fill, stall five cycles, drain
      ta = '{16'd10, 16'hFFFF, 16'h00FF, 16'h7FFF};
      tb = '{16'd20, 16'hFFFF, 16'h0F00, 16'h0001};
      tc = '{1'b0, 1'b1, 1'b1, 1'b0};
      es = '{16'd30, 16'hFFFF, 16'h1000, 16'h8000};
      ec = '{1'b0, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ta[k], tb[k], tc[k]);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      for (int s = 0; s < 5; s++) begin
         check($sformatf("bp_valid%0d", s),    64'(out_valid), 64'(1));
         check($sformatf("bp_in_ready%0d", s), 64'(in_ready),  64'(0));
         check($sformatf("bp_sum%0d", s),      64'(sum),       64'(es[0]));
         check($sformatf("bp_cout%0d", s),     64'(cout),      64'(ec[0]));
         tick();
      end
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("bp_out_valid%0d", k), 64'(out_valid), 64'(1));
         check($sformatf("bp_out_sum%0d", k),   64'(sum),       64'(es[k]));
         check($sformatf("bp_out_cout%0d", k),  64'(cout),      64'(ec[k]));
         tick();
      end
      check("bp_gone", 64'(out_valid), 64'(0));

      // reset with two beats in flight
      drive(1'b1, 16'd5, 16'd6, 1'b0);
      tick();
      drive(1'b1, 16'hABCD, 16'h1111, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_valid",    64'(out_valid), 64'(0));
      check("mrst_sum",      64'(sum),       64'(0));
      check("mrst_cout",     64'(cout),      64'(0));
      check("mrst_in_ready", 64'(in_ready),  64'(1));
      tick();
      rst = 1'b0;
      for (int s = 0; s < 6; s++) begin
         tick();
         check($sformatf("mrst_quiet%0d", s), 64'(out_valid), 64'(0));
      end
      drive(1'b1, 16'd9, 16'd9, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check("mrst_new_early", 64'(out_valid), 64'(0));
      tick();
      check("mrst_new_valid", 64'(out_valid), 64'(1));
      check("mrst_new_sum",   64'(sum),       64'(16'h0013));
      tick();
`else
      // low part OR-approximated, cin ignored
      drive(1'b1, 16'h000F, 16'h0001, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check("apx_early", 64'(out_valid), 64'(0));
      tick();
      check("apx_valid", 64'(out_valid), 64'(1));
      check("apx_sum",   64'(sum),       64'(16'h000F));
      check("apx_cout",  64'(cout),      64'(0));
      tick();
`endif

      // random traffic against the arithmetic model
      for (int n = 0; n < 400; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         drive($urandom_range(0, 3) != 0, ra, rb, rc);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid) begin
            if (q.size() == 0) begin
               check("rnd_spurious", 64'(out_valid), 64'(0));
            end else begin
               check("rnd_data", 64'({cout, sum}), 64'(q[0]));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(ra, rb, rc));
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      out_ready = 1'b1;
      #1;
      for (int n = 0; n < 10; n++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("drain_spurious", 64'(out_valid), 64'(0));
            end else begin
               check("drain_data", 64'({cout, sum}), 64'(q[0]));
               void'(q.pop_front());
            end
         end
         tick();
      end
      check("drain_empty", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
